// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and the register-bank address decoder.
package axi4_lite_pkg;

   localparam int unsigned MAX_IDX_W  = 8;
   localparam int unsigned MAX_ADDR_W = 64;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef struct packed {
      logic                 ok;
      logic [MAX_IDX_W-1:0] idx;
   } idx_res_t;

   function automatic int unsigned idx_w_of(input int unsigned num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   // Word index plus in-range flag; any set bit above the index field is a miss.
   function automatic idx_res_t addr_to_idx(input logic [MAX_ADDR_W-1:0] addr,
                                            input int unsigned addr_lsb,
                                            input int unsigned idx_w,
                                            input int unsigned num_regs);
      idx_res_t              res;
      logic [MAX_ADDR_W-1:0] shifted;
      shifted = addr >> addr_lsb;
      res.idx = MAX_IDX_W'(shifted & ((MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1)));
      res.ok  = ((shifted >> idx_w) == '0) && (32'(res.idx) < num_regs);
      return res;
   endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi4_lite_if #(
   parameter int unsigned ADDR_BIT_WIDTH = 32,
   parameter int unsigned DATA_BIT_WIDTH = 32
);
   logic [ADDR_BIT_WIDTH-1:0]   awaddr;
   logic [2:0]                  awprot;
   logic                        awvalid;
   logic                        awready;
   logic [DATA_BIT_WIDTH-1:0]   wdata;
   logic [DATA_BIT_WIDTH/8-1:0] wstrb;
   logic                        wvalid;
   logic                        wready;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic [ADDR_BIT_WIDTH-1:0]   araddr;
   logic [2:0]                  arprot;
   logic                        arvalid;
   logic                        arready;
   logic [DATA_BIT_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;
   logic                        rvalid;
   logic                        rready;

   modport slv_port (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport mst_port (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_slv_wr_ctrl.sv
// Write channel control: independent AW/W holding latches, commit decision and B response.
module axi4_lite_slv_wr_ctrl
   import axi4_lite_pkg::*;
#(
   parameter int unsigned ADDR_BIT_WIDTH = 32,
   parameter int unsigned DATA_BIT_WIDTH = 32,
   parameter int unsigned NUM_REGS       = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0,
   localparam int unsigned STRB_W   = DATA_BIT_WIDTH / 8,
   localparam int unsigned ADDR_LSB = $clog2(STRB_W),
   localparam int unsigned IDX_W    = idx_w_of(NUM_REGS)
) (
   input  logic                      i_clk,
   input  logic                      i_sync_rst,
   input  logic [ADDR_BIT_WIDTH-1:0] awaddr,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [DATA_BIT_WIDTH-1:0] wdata,
   input  logic [STRB_W-1:0]         wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic                      bvalid,
   output logic [1:0]                bresp,
   input  logic                      bready,
   output logic                      commit_c,
   output logic [IDX_W-1:0]          commit_idx_c,
   output logic [DATA_BIT_WIDTH-1:0] commit_wdata_c,
   output logic [STRB_W-1:0]         commit_wstrb_c
);

   logic                      aw_full, w_full;
   logic [ADDR_BIT_WIDTH-1:0] aw_addr;
   logic [DATA_BIT_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]         w_strb;
   logic                      aw_hs, w_hs, commit, wr_ok;
   logic                      aw_full_nxt, w_full_nxt, bvalid_nxt;
   idx_res_t                  dec;
   logic [IDX_W-1:0]          dec_idx;

   // Commit waits for both halves and for the previous B to drain.
   always_comb begin
      aw_hs       = awvalid && awready;
      w_hs        = wvalid && wready;
      commit      = aw_full && w_full && !bvalid;
      dec         = addr_to_idx(MAX_ADDR_W'(aw_addr), ADDR_LSB, IDX_W, NUM_REGS);
      dec_idx     = IDX_W'(dec.idx);
      wr_ok       = dec.ok && !RO_MASK[dec_idx];
      aw_full_nxt = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_full);
      w_full_nxt  = commit ? 1'b0 : (w_hs  ? 1'b1 : w_full);
      bvalid_nxt  = commit ? 1'b1 : ((bvalid && bready) ? 1'b0 : bvalid);
   end

   assign commit_c       = commit && wr_ok;
   assign commit_idx_c   = dec_idx;
   assign commit_wdata_c = w_data;
   assign commit_wstrb_c = w_strb;

   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
         aw_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
      end else begin
         aw_full <= aw_full_nxt;
         w_full  <= w_full_nxt;
         awready <= !aw_full_nxt;
         wready  <= !w_full_nxt;
         bvalid  <= bvalid_nxt;
         if (aw_hs) aw_addr <= awaddr;
         if (w_hs) begin
            w_data <= wdata;
            w_strb <= wstrb;
         end
         if (commit) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

endmodule

// File: rtl/axi4_lite_slv_reg_bank.sv
// AXI4-Lite slave register bank: RW control words to fabric, RO status words from fabric.
module axi4_lite_slv_reg_bank
   import axi4_lite_pkg::*;
#(
   parameter int unsigned ADDR_BIT_WIDTH = 32,
   parameter int unsigned DATA_BIT_WIDTH = 32,
   parameter int unsigned NUM_REGS       = 8,
   parameter logic [NUM_REGS-1:0]                RO_MASK  = '0,
   parameter logic [NUM_REGS*DATA_BIT_WIDTH-1:0] RST_VALS = '0
) (
   input  logic                               i_clk,
   input  logic                               i_sync_rst,
   axi4_lite_if.slv_port                      if_s_axi,
   output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_regs,
   input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] i_ro_vals,
   output logic [NUM_REGS-1:0]                o_wr_pulse
);

   localparam int unsigned DW       = DATA_BIT_WIDTH;
   localparam int unsigned STRB_W   = DW / 8;
   localparam int unsigned ADDR_LSB = $clog2(STRB_W);
   localparam int unsigned IDX_W    = idx_w_of(NUM_REGS);

   logic [DW-1:0]     regs     [NUM_REGS];
   logic [DW-1:0]     ro_words [NUM_REGS];
   logic              awready, wready, bvalid;
   logic [1:0]        bresp;
   logic              commit_c;
   logic [IDX_W-1:0]  commit_idx_c;
   logic [DW-1:0]     commit_wdata_c;
   logic [STRB_W-1:0] commit_wstrb_c;
   logic              arready, rvalid, ar_hs;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp;
   idx_res_t          rd_dec;
   logic [IDX_W-1:0]  rd_idx;
   logic              unused_prot;

   assign unused_prot = ^{if_s_axi.awprot, if_s_axi.arprot};

   axi4_lite_slv_wr_ctrl #(
      .ADDR_BIT_WIDTH (ADDR_BIT_WIDTH),
      .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
      .NUM_REGS       (NUM_REGS),
      .RO_MASK        (RO_MASK)
   ) u_wr_ctrl (
      .i_clk          (i_clk),
      .i_sync_rst     (i_sync_rst),
      .awaddr         (if_s_axi.awaddr),
      .awvalid        (if_s_axi.awvalid),
      .awready        (awready),
      .wdata          (if_s_axi.wdata),
      .wstrb          (if_s_axi.wstrb),
      .wvalid         (if_s_axi.wvalid),
      .wready         (wready),
      .bvalid         (bvalid),
      .bresp          (bresp),
      .bready         (if_s_axi.bready),
      .commit_c       (commit_c),
      .commit_idx_c   (commit_idx_c),
      .commit_wdata_c (commit_wdata_c),
      .commit_wstrb_c (commit_wstrb_c)
   );

   assign if_s_axi.awready = awready;
   assign if_s_axi.wready  = wready;
   assign if_s_axi.bvalid  = bvalid;
   assign if_s_axi.bresp   = bresp;
   assign if_s_axi.arready = arready;
   assign if_s_axi.rvalid  = rvalid;
   assign if_s_axi.rdata   = rdata;
   assign if_s_axi.rresp   = rresp;

   always_comb begin
      o_regs = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         o_regs[i*DW +: DW] = regs[i];
         ro_words[i]        = i_ro_vals[i*DW +: DW];
      end
   end

   // Register array; read-only slots stay at zero since commit never targets them.
   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= RO_MASK[i] ? '0 : RST_VALS[i*DW +: DW];
         o_wr_pulse <= '0;
      end else begin
         o_wr_pulse <= '0;
         if (commit_c) begin
            for (int b = 0; b < STRB_W; b++)
               if (commit_wstrb_c[b]) regs[commit_idx_c][b*8 +: 8] <= commit_wdata_c[b*8 +: 8];
            o_wr_pulse[commit_idx_c] <= 1'b1;
         end
      end
   end

   always_comb begin
      ar_hs  = if_s_axi.arvalid && arready;
      rd_dec = addr_to_idx(MAX_ADDR_W'(if_s_axi.araddr), ADDR_LSB, IDX_W, NUM_REGS);
      rd_idx = IDX_W'(rd_dec.idx);
   end

   // Read path samples the pre-commit register value when both land on one edge.
   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         rvalid  <= 1'b0;
         arready <= 1'b0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
      end else begin
         if (ar_hs) begin
            rvalid  <= 1'b1;
            arready <= 1'b0;
            if (!rd_dec.ok) begin
               rdata <= '0;
               rresp <= RESP_SLVERR;
            end else begin
               rdata <= RO_MASK[rd_idx] ? ro_words[rd_idx] : regs[rd_idx];
               rresp <= RESP_OKAY;
            end
         end else if (rvalid && if_s_axi.rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
         end else begin
            arready <= !rvalid;
         end
      end
   end

endmodule

// File: tb/tb_axi4_lite_slv_reg_bank.sv
// Directed self-checking bench for axi4_lite_slv_reg_bank (8 x 32-bit, slot 7 read-only).
module tb_axi4_lite_slv_reg_bank;

   localparam logic [255:0] RST_VALS = {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                                        32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
   localparam logic [255:0] RST_EXP  = {32'h0000_0000, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                                        32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] o_regs;
   logic [255:0] ro_vals;
   logic [7:0]   o_wr_pulse;
   int           checks = 0;
   int           errors = 0;
   logic [31:0]  rd_data;
   logic [1:0]   rd_resp, wr_resp;
   logic [7:0]   wr_pulse;

   axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) bus ();

   axi4_lite_slv_reg_bank #(
      .ADDR_BIT_WIDTH (32),
      .DATA_BIT_WIDTH (32),
      .NUM_REGS       (8),
      .RO_MASK        (8'h80),
      .RST_VALS       (RST_VALS)
   ) dut (
      .i_clk      (clk),
      .i_sync_rst (rst),
      .if_s_axi   (bus.slv_port),
      .o_regs     (o_regs),
      .i_ro_vals  (ro_vals),
      .o_wr_pulse (o_wr_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [7:0] pulse);
      logic aw_hs, w_hs;
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      for (int n = 0; n < 20 && (bus.awvalid || bus.wvalid); n++) begin
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         step();
         if (aw_hs) bus.awvalid = 1'b0;
         if (w_hs)  bus.wvalid  = 1'b0;
      end
      check("wr_handshake", {bus.awvalid, bus.wvalid}, 0);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b1;
      for (int n = 0; n < 20 && !bus.bvalid; n++) step();
      check("wr_bvalid", bus.bvalid, 1);
      resp  = bus.bresp;
      pulse = o_wr_pulse;
      step();
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic ar_hs;
      bus.araddr = addr; bus.arvalid = 1'b1;
      for (int n = 0; n < 20 && bus.arvalid; n++) begin
         ar_hs = bus.arvalid && bus.arready;
         step();
         if (ar_hs) bus.arvalid = 1'b0;
      end
      check("rd_handshake", bus.arvalid, 0);
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      for (int n = 0; n < 20 && !bus.rvalid; n++) step();
      check("rd_rvalid", bus.rvalid, 1);
      check("rd_arready_low", bus.arready, 0);
      data = bus.rdata;
      resp = bus.rresp;
      step();
      bus.rready = 1'b0;
   endtask

   initial begin
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      ro_vals = {32'h1000_0007, 32'hEEEE_0006, 32'hEEEE_0005, 32'hEEEE_0004,
                 32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};

      // Reset state
      repeat (3) step();
      check("rst_awready", bus.awready, 0);
      check("rst_wready", bus.wready, 0);
      check("rst_arready", bus.arready, 0);
      check("rst_bvalid", bus.bvalid, 0);
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_resp", {bus.bresp, bus.rresp}, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_pulse", o_wr_pulse, 0);
      check("rst_regs", o_regs, RST_EXP);
      rst = 1'b0;
      step();
      check("ready_after_rst", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // Read back reset values, slot 7 from the status input
      for (int i = 0; i < 8; i++) begin
         axi_read(32'(i * 4), rd_data, rd_resp);
         check($sformatf("rst_read%0d_data", i), rd_data, 32'h1000_0000 + 32'(i));
         check($sformatf("rst_read%0d_resp", i), rd_resp, 2'b00);
      end

      // Preload reg2 = 0 and reg3 = 5
      axi_write(32'h08, 32'h0, 4'hF, wr_resp, wr_pulse);
      check("pre2_resp", wr_resp, 2'b00);
      axi_write(32'h0C, 32'h5, 4'hF, wr_resp, wr_pulse);
      check("pre3_pulse", wr_pulse, 8'h08);

      // Simultaneous AW+W with partial strobe
      bus.awaddr = 32'h08; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'b0101;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("strb_bvalid_early", bus.bvalid, 0);
      step();
      check("strb_bvalid", bus.bvalid, 1);
      check("strb_bresp", bus.bresp, 2'b00);
      check("strb_reg2", o_regs[2*32 +: 32], 32'h00AD_00EF);
      check("strb_pulse", o_wr_pulse, 8'b0000_0100);
      step();
      check("strb_pulse_clear", o_wr_pulse, 0);
      check("strb_bvalid_hold", bus.bvalid, 1);
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
      check("strb_bvalid_done", bus.bvalid, 0);

      // W five cycles ahead of AW, then B stalled with a second write queued
      bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      repeat (4) step();
      check("early_w_no_bvalid", bus.bvalid, 0);
      bus.awaddr = 32'h04; bus.awvalid = 1'b1;
      step();
      bus.awvalid = 1'b0;
      step();
      check("early_w_bvalid", bus.bvalid, 1);
      check("early_w_reg1", o_regs[1*32 +: 32], 32'h1234_5678);
      check("early_w_pulse", o_wr_pulse, 8'h02);
      bus.awaddr = 32'h00; bus.wdata = 32'h0000_0011; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      for (int n = 0; n < 9; n++) begin
         check("stall_bvalid", bus.bvalid, 1);
         check("stall_bresp", bus.bresp, 2'b00);
         check("stall_reg0", o_regs[0 +: 32], 32'h1000_0000);
         check("stall_ready", {bus.awready, bus.wready, o_wr_pulse}, 0);
         step();
      end
      bus.bready = 1'b1;
      step();
      check("stall_b_done", bus.bvalid, 0);
      check("stall_reg0_hold", o_regs[0 +: 32], 32'h1000_0000);
      step();
      check("second_bvalid", bus.bvalid, 1);
      check("second_reg0", o_regs[0 +: 32], 32'h0000_0011);
      check("second_pulse", o_wr_pulse, 8'h01);
      step();
      bus.bready = 1'b0;

      // Out-of-range and read-only write targets
      axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, wr_resp, wr_pulse);
      check("oor_wr_resp", wr_resp, 2'b10);
      check("oor_wr_pulse", wr_pulse, 0);
      axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF, wr_resp, wr_pulse);
      check("ro_wr_resp", wr_resp, 2'b10);
      check("ro_wr_pulse", wr_pulse, 0);
      check("err_regs", o_regs, {32'h0, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                                 32'h5, 32'h00AD_00EF, 32'h1234_5678, 32'h11});
      axi_read(32'h40, rd_data, rd_resp);
      check("oor_rd_data", rd_data, 0);
      check("oor_rd_resp", rd_resp, 2'b10);
      axi_read(32'h1000_0008, rd_data, rd_resp);
      check("hi_bits_rd_resp", rd_resp, 2'b10);
      ro_vals[7*32 +: 32] = 32'hCAFE_F00D;
      axi_read(32'h1C, rd_data, rd_resp);
      check("ro_rd_data", rd_data, 32'hCAFE_F00D);
      check("ro_rd_resp", rd_resp, 2'b00);
      axi_read(32'h0B, rd_data, rd_resp);
      check("lowbits_rd_data", rd_data, 32'h00AD_00EF);

      // Read and commit to reg3 on the same edge
      bus.awaddr = 32'h0C; bus.wdata = 32'hAAAA_AAAA; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.araddr = 32'h0C; bus.arvalid = 1'b1;
      step();
      bus.arvalid = 1'b0;
      check("same_edge_rvalid", bus.rvalid, 1);
      check("same_edge_rdata", bus.rdata, 32'h5);
      check("same_edge_reg3", o_regs[3*32 +: 32], 32'hAAAA_AAAA);
      bus.rready = 1'b1; bus.bready = 1'b1;
      step();
      bus.rready = 1'b0; bus.bready = 1'b0;
      axi_read(32'h0C, rd_data, rd_resp);
      check("after_rdata", rd_data, 32'hAAAA_AAAA);

      // Reset while an AW is held and a read response is pending
      bus.awaddr = 32'h10; bus.awvalid = 1'b1;
      bus.araddr = 32'h00; bus.arvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.arvalid = 1'b0;
      check("pre_rst_state", {bus.rvalid, bus.awready}, 2'b10);
      rst = 1'b1;
      step();
      check("mid_rst_valids", {bus.bvalid, bus.rvalid}, 0);
      check("mid_rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
      check("mid_rst_regs", o_regs, RST_EXP);
      rst = 1'b0;
      bus.wdata = 32'h0000_0077; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      for (int n = 0; n < 6; n++) begin
         logic w_hs;
         w_hs = bus.wvalid && bus.wready;
         step();
         if (w_hs) bus.wvalid = 1'b0;
         check("post_rst_no_bvalid", bus.bvalid, 0);
      end
      check("post_rst_reg4", o_regs[4*32 +: 32], 32'h1000_0004);
      check("post_rst_awready", bus.awready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
